// File: rtl/tri_pkg.sv
// Shared constants for the triangle classifier: class codes, FSM encoding and
// width helpers for the pairwise sums and the optional right-angle squares.
package tri_pkg;

  localparam logic [2:0] CLS_NOT_TRI     = 3'd0;
  localparam logic [2:0] CLS_SCALENE     = 3'd1;
  localparam logic [2:0] CLS_ISOSCELES   = 3'd2;
  localparam logic [2:0] CLS_EQUILATERAL = 3'd3;
  localparam logic [2:0] CLS_RIGHT       = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_EVAL = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // One extra bit keeps any pairwise sum of W-bit sides exact.
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int sq_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/tri_eval.sv
// Combinational classification of three sides into a class code.
// Right-triangle detection is built only when TRI_RIGHT_DETECT_EN is defined.
module tri_eval
  import tri_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [2:0]   class_o
);

  localparam int SW = sum_w(W);

  logic [SW-1:0] sumAb, sumAc, sumBc;
  logic          isTri, eqAb, eqBc, eqAc, isEqui, isIso, isRight;

  assign sumAb = SW'(a_i) + SW'(b_i);
  assign sumAc = SW'(a_i) + SW'(c_i);
  assign sumBc = SW'(b_i) + SW'(c_i);

  assign isTri = (sumAb > SW'(c_i)) && (sumAc > SW'(b_i)) && (sumBc > SW'(a_i));

  assign eqAb   = (a_i == b_i);
  assign eqBc   = (b_i == c_i);
  assign eqAc   = (a_i == c_i);
  assign isEqui = eqAb && eqBc;
  assign isIso  = (eqAb || eqBc || eqAc) && !isEqui;

`ifdef TRI_RIGHT_DETECT_EN
  localparam int QW = sq_w(W);

  logic [W-1:0]  sideM, sideP, sideQ;
  logic [QW-1:0] sqLegs, sqHyp;

  // Longest side becomes the hypotenuse candidate; the other two are legs.
  always_comb begin
    sideM = c_i;
    sideP = a_i;
    sideQ = b_i;
    if (a_i >= b_i && a_i >= c_i) begin
      sideM = a_i;
      sideP = b_i;
      sideQ = c_i;
    end else if (b_i >= c_i) begin
      sideM = b_i;
      sideP = a_i;
      sideQ = c_i;
    end
  end

  assign sqLegs  = QW'(sideP) * QW'(sideP) + QW'(sideQ) * QW'(sideQ);
  assign sqHyp   = QW'(sideM) * QW'(sideM);
  assign isRight = (sqLegs == sqHyp);
`else
  assign isRight = 1'b0;
`endif

  always_comb begin
    class_o = CLS_NOT_TRI;
    if (isTri) begin
      if (isEqui)       class_o = CLS_EQUILATERAL;
      else if (isIso)   class_o = CLS_ISOSCELES;
      else if (isRight) class_o = CLS_RIGHT;
      else              class_o = CLS_SCALENE;
    end
  end

endmodule

// File: rtl/tri_classifier.sv
// Serial three-side triangle classifier with configurable output latency and
// protocol-error pulses. Optional right detection: TRI_RIGHT_DETECT_EN.
module tri_classifier
  import tri_pkg::*;
#(
  parameter int W       = 3,
  parameter int OUT_LAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  input  logic [W-1:0] INPUT,
  output logic         OUT,
  output logic [2:0]   OUT_CLASS,
  output logic         OUT_VALID,
  output logic         BUSY,
  output logic         ERR
);

  localparam int CW = 4;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    eval_q, eval_d;
  logic [2:0]    outClass_q, outClass_d;
  logic          outValid_q, outValid_d;
  logic          err_q, err_d;
  logic [2:0]    evalClass;

  tri_eval #(.W(W)) uEval (
    .a_i     (a_q),
    .b_i     (b_q),
    .c_i     (c_q),
    .class_o (evalClass)
  );

  // WAIT lasts OUT_LAT cycles so the strobe lands OUT_LAT+1 edges after side c.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    eval_d     = eval_q;
    outClass_d = outClass_q;
    outValid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (IN_VALID) begin
          a_d     = INPUT;
          state_d = ST_S1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_S1: begin
        if (IN_VALID) begin
          b_d     = INPUT;
          state_d = ST_S2;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_S2: begin
        if (IN_VALID) begin
          c_d     = INPUT;
          state_d = ST_EVAL;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        err_d   = IN_VALID;
        eval_d  = evalClass;
        cnt_d   = CW'(OUT_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        err_d = IN_VALID;
        if (cnt_q == '0) begin
          outClass_d = eval_q;
          outValid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      eval_q     <= CLS_NOT_TRI;
      outClass_q <= CLS_NOT_TRI;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      eval_q     <= eval_d;
      outClass_q <= outClass_d;
      outValid_q <= outValid_d;
      err_q      <= err_d;
    end
  end

  assign OUT       = (outClass_q != CLS_NOT_TRI);
  assign OUT_CLASS = outClass_q;
  assign OUT_VALID = outValid_q;
  assign BUSY      = (state_q == ST_EVAL) || (state_q == ST_WAIT);
  assign ERR       = err_q;

endmodule

// File: tb/tb_tri_classifier.sv
// Drives one shared serial stream into a W=3/OUT_LAT=1 and a W=8/OUT_LAT=3
// classifier and compares every cycle against a timestamp-based reference.
module tb_tri_classifier;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic       CLK, RST, IN_VALID;
  logic [7:0] inp;

  logic       out0, vld0, busy0, err0;
  logic [2:0] cls0;
  logic       out1, vld1, busy1, err1;
  logic [2:0] cls1;

  int nCompared   = 0;
  int nMismatched = 0;
  int e = 0;

  // Reference state per DUT: sides collected so far, edge of side c, edge of
  // the result strobe, class waiting to be shown, class currently shown.
  int mN[2];
  int mS[2][3];
  int mK[2];
  int mRes[2];
  int mPend[2];
  int mHeld[2];
  bit mErr[2];

  tri_classifier #(.W(3), .OUT_LAT(LAT0)) u0 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .INPUT(inp[2:0]),
    .OUT(out0), .OUT_CLASS(cls0), .OUT_VALID(vld0), .BUSY(busy0), .ERR(err0)
  );

  tri_classifier #(.W(8), .OUT_LAT(LAT1)) u1 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .INPUT(inp),
    .OUT(out1), .OUT_CLASS(cls1), .OUT_VALID(vld1), .BUSY(busy1), .ERR(err1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int refClass(input int a, input int b, input int c);
    if (!(a + b > c && a + c > b && b + c > a)) return 0;
    if (a == b && b == c) return 3;
    if (a == b || b == c || a == c) return 2;
`ifdef TRI_RIGHT_DETECT_EN
    if (a*a + b*b == c*c || a*a + c*c == b*b || b*b + c*c == a*a) return 4;
`endif
    return 1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mN[d] = 0; mK[d] = -1; mRes[d] = -1; mPend[d] = 0; mHeld[d] = 0; mErr[d] = 1'b0;
    end
  endtask

  task automatic modelStep(input int d, input bit v, input int x);
    int xv, lat;
    xv  = (d == 0) ? (x & 7) : (x & 255);
    lat = (d == 0) ? LAT0 : LAT1;
    mErr[d] = 1'b0;
    if (mRes[d] >= 0 && e <= mRes[d]) begin
      if (v) mErr[d] = 1'b1;
    end else if (v) begin
      mS[d][mN[d]] = xv;
      mN[d]++;
      if (mN[d] == 3) begin
        mK[d]    = e;
        mRes[d]  = e + lat + 1;
        mPend[d] = refClass(mS[d][0], mS[d][1], mS[d][2]);
        mN[d]    = 0;
      end
    end else if (mN[d] > 0) begin
      mErr[d] = 1'b1;
      mN[d]   = 0;
    end
    if (e == mRes[d]) mHeld[d] = mPend[d];
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input int d);
    int expBusy;
    expBusy = (mRes[d] >= 0 && e >= mK[d] && e < mRes[d]) ? 1 : 0;
    checkOutput($sformatf("u%0d.valid@%0d", d, e), (d == 0) ? int'(vld0) : int'(vld1),
                (mRes[d] >= 0 && e == mRes[d]) ? 1 : 0);
    checkOutput($sformatf("u%0d.class@%0d", d, e), (d == 0) ? int'(cls0) : int'(cls1), mHeld[d]);
    checkOutput($sformatf("u%0d.out@%0d", d, e), (d == 0) ? int'(out0) : int'(out1),
                (mHeld[d] != 0) ? 1 : 0);
    checkOutput($sformatf("u%0d.busy@%0d", d, e), (d == 0) ? int'(busy0) : int'(busy1), expBusy);
    checkOutput($sformatf("u%0d.err@%0d", d, e), (d == 0) ? int'(err0) : int'(err1), int'(mErr[d]));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic applyStimulus(input bit v, input int x);
    IN_VALID = v;
    inp      = 8'(x);
    @(posedge CLK);
    e++;
    modelStep(0, v, x);
    modelStep(1, v, x);
    @(negedge CLK);
    checkDut(0);
    checkDut(1);
  endtask

  task automatic sendTriple(input int a, input int b, input int c);
    applyStimulus(1'b1, a);
    applyStimulus(1'b1, b);
    applyStimulus(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  task automatic applyReset();
    RST      = 1'b1;
    IN_VALID = 1'b0;
    #1;
    modelReset();
    checkDut(0);
    checkDut(1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    inp      = '0;
    modelReset();
    repeat (2) @(negedge CLK);
    checkDut(0);
    checkDut(1);
    RST = 1'b0;

    sendTriple(7, 7, 7);     idle(6);
    sendTriple(1, 2, 1);     idle(6);
    sendTriple(3, 1, 1);     idle(6);
    sendTriple(3, 4, 6);     idle(6);
    sendTriple(3, 4, 5);     idle(6);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b1, 2);
    idle(4);
    sendTriple(2, 2, 3);     idle(6);
    sendTriple(5, 5, 5);
    applyStimulus(1'b1, 9);
    idle(3);
    sendTriple(4, 5, 6);     idle(8);
    sendTriple(255, 255, 1); idle(8);
    sendTriple(0, 4, 4);     idle(8);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b1, 4);
    applyReset();
    idle(8);

    for (int i = 0; i < 400; i++) begin
      bit v;
      int x;
      v = ($urandom_range(0, 9) != 0);
      x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 255));
      applyStimulus(v, x);
      if (i == 200) applyReset();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
